uart_paddle_router: RTL and testbench

- Sits between the UART2 byte receiver and the game renderer.
- Parses framed multi-player position packets from the single serial link and validates each frame.
- Routes each valid frame's scaled Y position to one of four per-player registers.
- Replaces the single-paddle two-byte scheme, giving up to four controllers a shared link with resync and error reporting.

---
 rtl/uart_paddle_router.sv | 189 ++++++++++++++++++
 tb/tb_uart_paddle_router.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_paddle_router.sv
// ---------------------------------------------------------------------------
// uart_paddle_router
//
// Parses framed position packets arriving byte-by-byte from the UART2
// receiver. Each valid frame carries a player id and a 10-bit raw value. The
// raw value is scaled to a screen Y position and written to that player's
// register. Malformed or stalled frames are rejected, and the cause is
// reported.
//
// Frame layout: HDR (0xA0 | id), LO, HI[, CHK = HDR ^ LO ^ HI]
//   Optional feature macro: UART_ROUTER_CHECKSUM_EN
//     defined   -> four-byte frames, the trailing checksum byte is verified
//     undefined -> three-byte frames, accepted on the HI byte
//
// Ports
//   CLOCK       in   system clock (rising edge)
//   reset       in   asynchronous active-high reset
//   rx_data     in   [7:0] byte from UART2
//   rx_toggle   in   UART2 dataAvail; each level change marks one new byte
//   pointY_all  out  [39:0] four 10-bit positions, player n at [10n+9:10n]
//   pkt_ok      out  one-cycle pulse when a frame is accepted
//   pkt_err     out  one-cycle pulse when a frame is rejected
//   err_code    out  [1:0] last error: 1 checksum, 2 timeout, 3 bad high byte
//   err_count   out  [7:0] saturating count of rejected frames
//   leds        out  [9:0] raw value of the last accepted frame
// ---------------------------------------------------------------------------
module uart_paddle_router #(
  parameter int TIMEOUT_CYC = 350000,
  parameter int POS_OFFSET  = 99,
  parameter int RESET_POS   = 227
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_toggle,
  output logic [39:0] pointY_all,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  output logic [9:0]  leds
);

  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT_CYC);
  localparam logic [9:0]      OFFSET_V  = 10'(POS_OFFSET);
  localparam logic [9:0]      RESET_V   = 10'(RESET_POS);
  localparam logic [5:0]      HDR_TAG   = 6'b101000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_HDR = 2'd1,
    GOT_LO  = 2'd2
`ifdef UART_ROUTER_CHECKSUM_EN
    ,
    GOT_HI  = 2'd3
`endif
  } state_t;

  // (raw >> 2) is at most 255, so adding the offset fits in 10 bits.
  function automatic logic [9:0] scale_pos(input logic [9:0] raw);
    return (raw >> 2) + OFFSET_V;
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            toggle_q;
  logic [1:0]      id_q;
  logic [7:0]      lo_q;
  logic [9:0]      pos_q [4];
  logic            pkt_ok_q, pkt_err_q;
  logic [1:0]      err_code_q;
  logic [7:0]      err_count_q;
  logic [9:0]      leds_q;

  logic            byte_ev;
  logic            hdr_ok;
  logic            hi_ok;
  logic [9:0]      raw_w;
  logic            accept;
  logic            reject;
  logic [1:0]      rej_code;

  assign byte_ev = rx_toggle ^ toggle_q;
  assign hdr_ok  = (rx_data[7:2] == HDR_TAG);
  assign hi_ok   = (rx_data[7:2] == 6'd0);

`ifdef UART_ROUTER_CHECKSUM_EN
  // Only HI[1:0] is kept: HI[7:2] is known to be zero once GOT_HI is reached.
  logic [1:0] hi_q;
  logic [7:0] chk_w;
  assign raw_w = {hi_q, lo_q};
  assign chk_w = {HDR_TAG, id_q} ^ lo_q ^ {6'd0, hi_q};
`else
  assign raw_w = {rx_data[1:0], lo_q};
`endif

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    rej_code = 2'd0;
    timer_d  = (state_q == IDLE) ? '0 : timer_q + 1'b1;
    if (byte_ev) begin
      // A byte event always wins over a coincident timeout.
      timer_d = '0;
      case (state_q)
        IDLE:    if (hdr_ok) state_d = GOT_HDR;
        GOT_HDR: state_d = GOT_LO;
        GOT_LO: begin
          if (!hi_ok) begin
            reject   = 1'b1;
            rej_code = 2'd3;
            state_d  = IDLE;
          end else begin
`ifdef UART_ROUTER_CHECKSUM_EN
            state_d = GOT_HI;
`else
            accept  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
`ifdef UART_ROUTER_CHECKSUM_EN
        GOT_HI: begin
          if (rx_data == chk_w) begin
            accept = 1'b1;
          end else begin
            reject   = 1'b1;
            rej_code = 2'd1;
          end
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TIMEOUT_V) begin
      reject   = 1'b1;
      rej_code = 2'd2;
      state_d  = IDLE;
      timer_d  = '0;
    end
  end

  // Frame payload capture; contents are only meaningful while the FSM holds them.
  always_ff @(posedge CLOCK) begin
    if (byte_ev && state_q == IDLE)    id_q <= rx_data[1:0];
    if (byte_ev && state_q == GOT_HDR) lo_q <= rx_data;
`ifdef UART_ROUTER_CHECKSUM_EN
    if (byte_ev && state_q == GOT_LO)  hi_q <= rx_data[1:0];
`endif
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      toggle_q    <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 2'd0;
      err_count_q <= 8'd0;
      leds_q      <= 10'd0;
      for (int i = 0; i < 4; i++) pos_q[i] <= RESET_V;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      toggle_q  <= rx_toggle;
      pkt_ok_q  <= accept;
      pkt_err_q <= reject;
      if (accept) begin
        pos_q[id_q] <= scale_pos(raw_w);
        leds_q      <= raw_w;
      end
      if (reject) begin
        err_code_q <= rej_code;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign pointY_all = {pos_q[3], pos_q[2], pos_q[1], pos_q[0]};
  assign pkt_ok     = pkt_ok_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;
  assign err_count  = err_count_q;
  assign leds       = leds_q;

endmodule

// File: tb/tb_uart_paddle_router.sv
// ---------------------------------------------------------------------------
// tb_uart_paddle_router
//
// Scoreboard bench for uart_paddle_router. Frames are scored by a small
// reference model as they are sent. Each pulse from the DUT pops one
// expectation and compares it against the outputs. Builds with or without
// UART_ROUTER_CHECKSUM_EN. The timeout is shortened to keep runs brief.
// ---------------------------------------------------------------------------
module tb_uart_paddle_router;

  localparam int TO = 40;

  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_toggle = 1'b0;
  logic [39:0] pointY_all;
  logic        pkt_ok, pkt_err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [9:0]  leds;

  uart_paddle_router #(.TIMEOUT_CYC(TO), .POS_OFFSET(99), .RESET_POS(227)) dut (
    .CLOCK(CLOCK), .reset(reset), .rx_data(rx_data), .rx_toggle(rx_toggle),
    .pointY_all(pointY_all), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .err_count(err_count), .leds(leds)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit          ok;
    logic [39:0] py;
    logic [9:0]  leds;
    logic [1:0]  code;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [9:0]  m_pos [4];
  logic [9:0]  m_leds;
  logic [1:0]  m_code;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] m_py();
    return {m_pos[3], m_pos[2], m_pos[1], m_pos[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pos[i] = 10'd227;
    m_leds = 10'd0;
    m_code = 2'd0;
    m_cnt  = 8'd0;
  endtask

  task automatic push_ok(input logic [1:0] id, input logic [9:0] raw);
    exp_t e;
    m_pos[id] = (raw >> 2) + 10'd99;
    m_leds    = raw;
    e = '{ok: 1'b1, py: m_py(), leds: m_leds, code: m_code, cnt: m_cnt};
    sbq.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    m_code = code;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e = '{ok: 1'b0, py: m_py(), leds: m_leds, code: m_code, cnt: m_cnt};
    sbq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLOCK);
    rx_data   = b;
    rx_toggle = ~rx_toggle;
    repeat (gap) @(negedge CLOCK);
  endtask

  // Frame with a valid header; gap = idle cycles between bytes.
  task automatic frame(input logic [7:0] h, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] ck, input int gap);
    send_byte(h, gap);
    send_byte(lo, gap);
    if (hi[7:2] != 6'd0) begin
      push_err(2'd3);
      send_byte(hi, 2);
    end else begin
`ifdef UART_ROUTER_CHECKSUM_EN
      send_byte(hi, gap);
      if (ck == (h ^ lo ^ hi)) push_ok(h[1:0], {hi[1:0], lo});
      else                     push_err(2'd1);
      send_byte(ck, 2);
`else
      push_ok(h[1:0], {hi[1:0], lo});
      send_byte(hi, 2);
      if (ck == 8'h00) ; // checksum byte is not part of a three-byte frame
`endif
    end
  endtask

  task automatic reset_checks();
    check("rst_pointY",    pointY_all, {4{10'd227}});
    check("rst_pkt_ok",    pkt_ok,     0);
    check("rst_pkt_err",   pkt_err,    0);
    check("rst_err_code",  err_code,   0);
    check("rst_err_count", err_count,  0);
    check("rst_leds",      leds,       0);
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation.
  always @(negedge CLOCK) begin : mon
    exp_t e;
    if (!reset && (pkt_ok || pkt_err)) begin
      if (sbq.size() == 0) begin
        check("spurious_pulse", {pkt_ok, pkt_err}, 0);
      end else begin
        e = sbq.pop_front();
        check("pkt_ok",  pkt_ok,  e.ok);
        check("pkt_err", pkt_err, !e.ok);
        check("pointY",  pointY_all, e.py);
        if (e.ok) begin
          check("leds", leds, e.leds);
        end else begin
          check("err_code",  err_code,  e.code);
          check("err_count", err_count, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [7:0] h, lo, hi, ck;
    model_reset();
    repeat (2) @(negedge CLOCK);
    reset_checks();
    reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    frame(8'hA1, 8'h10, 8'h02, 8'hB3, 1);
    frame(8'hA3, 8'hFF, 8'h03, 8'h5F, 1);
    frame(8'hA2, 8'hFF, 8'h03, 8'h00, 1);

    // Stall mid-frame past the timeout
    send_byte(8'hA0, 1);
    push_err(2'd2);
    send_byte(8'h10, TO + 5);
    frame(8'hA0, 8'h00, 8'h00, 8'hA0, 1);

    // Junk bytes in IDLE are dropped silently
    send_byte(8'h55, 1);
    send_byte(8'h00, 1);
    frame(8'hA1, 8'h10, 8'h02, 8'hB3, 1);
    frame(8'hA1, 8'h00, 8'h04, 8'hA5, 1);

    // Slow but in-time frame, back-to-back frame
    frame(8'hA2, 8'h40, 8'h01, 8'hA2 ^ 8'h40 ^ 8'h01, TO - 8);
    frame(8'hA0, 8'h37, 8'h02, 8'hA0 ^ 8'h37 ^ 8'h02, 0);

    // Random frames, some with a corrupted checksum or high byte
    for (int i = 0; i < 24; i++) begin
      h  = 8'hA0 | 8'($urandom_range(0, 3));
      lo = 8'($urandom_range(0, 255));
      hi = (i % 7 == 3) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      ck = h ^ lo ^ hi;
      if (i % 5 == 2) ck = ck ^ 8'h01;
      frame(h, lo, hi, ck, $urandom_range(0, 3));
    end

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) frame(8'hA3, 8'h00, 8'h80, 8'h23, 0);
    repeat (4) @(negedge CLOCK);
    check("err_count_sat", err_count, 8'hFF);
    check("queue_empty_1", sbq.size(), 0);

    // Reset in the middle of a frame
    send_byte(8'hA1, 1);
    send_byte(8'h10, 1);
    reset     = 1'b1;
    rx_toggle = 1'b0;
    model_reset();
    repeat (2) @(negedge CLOCK);
    reset_checks();
    reset = 1'b0;
    repeat (2) @(negedge CLOCK);
    frame(8'hA1, 8'h10, 8'h02, 8'hB3, 1);

    repeat (6) @(negedge CLOCK);
    check("queue_empty_2", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
